// File: rtl/apb_req_master_pkg.sv
// rtl/apb_req_master_pkg.sv - shared types for the APB request master
package apb_req_master_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic              we;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_req_master_if.sv
// rtl/apb_req_master_if.sv - APB3 bus bundle with master/slave views
interface APB_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_master_timeout_cnt.sv
// rtl/apb_req_master_timeout_cnt.sv - saturating ACCESS wait-state watchdog
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
      logic [CW-1:0] cnt;

      // Saturates at LIMIT so a long-hung slave never wraps back to "fresh".
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable && cnt != LIMIT) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign expired = (cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - valid/ready request channel to APB3 initiator with watchdog
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  input  logic                      req_we_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  APB_BUS.Master                    apb_master
);

  apb_mst_state_e            state;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      we_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic                      tmo_clear;
  logic                      tmo_enable;
  logic                      tmo_expired;

  assign tmo_clear  = (state == IDLE) && req_valid_i;
  assign tmo_enable = (state == ACCESS) && !apb_master.pready;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            we_q    <= req_we_i;
            psel_q  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion on the expiry cycle is not an error.
          if (apb_master.pready) begin
            rdata_q   <= we_q ? '0 : apb_master.prdata;
            err_q     <= apb_master.pslverr;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= RESP;
          end else if (tmo_expired) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o        = (state == IDLE);
  assign rsp_valid_o        = (state == RESP);
  assign rsp_rdata_o        = rdata_q;
  assign rsp_err_o          = err_q;
  assign apb_master.paddr   = addr_q;
  assign apb_master.pwdata  = wdata_q;
  assign apb_master.pwrite  = we_q;
  assign apb_master.psel    = psel_q;
  assign apb_master.penable = penable_q;

endmodule

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - scoreboard bench for apb_req_master
module tb_apb_req_master;
  import apb_req_master_pkg::*;

  localparam int T = 4;
  localparam int NEVER = 255;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_we_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  always #5 HCLK = ~HCLK;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb_req_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_we_i   (req_we_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .apb_master (apb)
  );

  typedef struct {
    apb_rsp_t rsp;
    int       due;
    int       stall;
  } exp_t;

  typedef struct {
    int          w;
    logic        err;
    logic [31:0] rdata;
  } slv_t;

  exp_t     sb[$];
  slv_t     sq[$];
  slv_t     scfg;
  apb_req_t cur;
  int       cyc = 0;
  int       tests = 0;
  int       fails = 0;
  int       last_pop = -100;
  int       k = 0;
  bit       in_reset = 1'b1;
  bit       seen = 1'b0;
  int       held = 0;
  bit       prev_setup = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Slave model: raises pready on ACCESS cycle index w (0-based); garbage elsewhere.
  always @(negedge HCLK) begin : slave
    if (in_reset) begin
      apb.pready  = 1'b0;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;
    end else if (apb.psel && !apb.penable) begin
      if (sq.size() > 0) scfg = sq.pop_front();
      k = 0;
      apb.pready  = 1'($urandom);
      apb.prdata  = $urandom;
      apb.pslverr = 1'($urandom);
    end else if (apb.psel && apb.penable) begin
      if (k == scfg.w) begin
        apb.pready  = 1'b1;
        apb.prdata  = scfg.rdata;
        apb.pslverr = scfg.err;
      end else begin
        apb.pready  = 1'b0;
        apb.prdata  = $urandom;
        apb.pslverr = 1'($urandom);
      end
      k++;
    end else begin
      apb.pready  = 1'($urandom);
      apb.prdata  = $urandom;
      apb.pslverr = 1'($urandom);
    end
  end

  always @(negedge HCLK) begin : monitor
    exp_t e;
    if (in_reset) begin
      rsp_ready_i = 1'b0;
      seen = 1'b0;
    end else if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        fail_now("spurious_rsp");
        rsp_ready_i = 1'b0;
      end else begin
        e = sb[0];
        chk("rsp_rdata", rsp_rdata_o, e.rsp.rdata);
        chk("rsp_err", rsp_err_o, e.rsp.err);
        if (!seen) begin
          chk("rsp_latency", cyc, e.due);
          seen = 1'b1;
          held = 0;
        end
        if (e.stall < 0) rsp_ready_i = ($urandom_range(0, 2) != 0);
        else rsp_ready_i = (held >= e.stall);
        held++;
        if (rsp_ready_i) begin
          void'(sb.pop_front());
          seen = 1'b0;
          last_pop = cyc;
        end
      end
    end else begin
      rsp_ready_i = 1'($urandom);
    end
  end

  always @(negedge HCLK) begin : proto
    if (in_reset) begin
      prev_setup = 1'b0;
    end else begin
      chk("req_ready_only_idle", req_ready_o, !(apb.psel || rsp_valid_o));
      if (prev_setup) chk("setup_then_access", {apb.psel, apb.penable}, 2'b11);
      if (apb.psel) begin
        chk("paddr_stable", apb.paddr, cur.addr);
        chk("pwdata_stable", apb.pwdata, cur.wdata);
        chk("pwrite_stable", apb.pwrite, cur.we);
      end
      if (rsp_valid_o) chk("bus_idle_in_resp", {apb.psel, apb.penable}, 2'b00);
      prev_setup = apb.psel && !apb.penable;
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input int w, input logic serr, input logic [31:0] rdata,
                       input int stall, input bit b2b, output int n_acc);
    int   guard;
    exp_t e;
    slv_t s;
    guard = 0;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_we_i    = we;
    req_valid_i = 1'b1;
    while (!req_ready_o && guard < 200) begin
      @(negedge HCLK);
      guard++;
    end
    if (!req_ready_o) begin
      fail_now("accept_timeout");
      req_valid_i = 1'b0;
      n_acc = -1;
      return;
    end
    n_acc = cyc;
    if (b2b) chk("b2b_accept_cycle", n_acc, last_pop + 1);
    cur.addr  = addr;
    cur.wdata = wdata;
    cur.we    = we;
    s.w     = w;
    s.err   = serr;
    s.rdata = rdata;
    sq.push_back(s);
    e.rsp.err   = (w > T) ? 1'b1 : serr;
    e.rsp.rdata = ((w > T) || we) ? 32'h0 : rdata;
    e.due       = n_acc + 3 + ((w > T) ? T : w);
    e.stall     = stall;
    sb.push_back(e);
    @(negedge HCLK);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_we_i    = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 300) begin
      @(negedge HCLK);
      g++;
    end
    if (sb.size() > 0) fail_now("drain_timeout");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n1, n2, n3, gap, w;
    repeat (3) @(negedge HCLK);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_psel", apb.psel, 1'b0);
    chk("rst_penable", apb.penable, 1'b0);
    chk("rst_pwrite", apb.pwrite, 1'b0);
    chk("rst_paddr", apb.paddr, 32'h0);
    chk("rst_pwdata", apb.pwdata, 32'h0);
    HRESETn  = 1'b1;
    in_reset = 1'b0;
    @(negedge HCLK);

    issue(32'h1A10_0004, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, $urandom, 0, 1'b0, n1);
    drain();
    issue(32'h1A10_1000, $urandom, 1'b0, 3, 1'b0, 32'h0000_00A5, 0, 1'b0, n1);
    drain();
    issue(32'h1A10_2000, $urandom, 1'b0, 0, 1'b1, $urandom, 0, 1'b0, n1);
    drain();
    issue(32'h1A10_3000, $urandom, 1'b0, NEVER, 1'b0, $urandom, 0, 1'b0, n1);
    drain();
    issue(32'h1A10_3004, $urandom, 1'b0, 3, 1'b0, $urandom, 0, 1'b0, n1);
    drain();
    issue(32'h1A10_3008, $urandom, 1'b0, T, 1'b0, $urandom, 0, 1'b0, n1);
    drain();
    issue(32'h1A10_300C, $urandom, 1'b1, T + 1, 1'b0, $urandom, 0, 1'b0, n1);
    drain();

    issue($urandom, $urandom, 1'b0, 1, 1'b0, $urandom, 5, 1'b0, n1);
    issue($urandom, $urandom, 1'b1, 0, 1'b0, $urandom, 0, 1'b1, n2);
    issue($urandom, $urandom, 1'b0, 0, 1'b0, $urandom, 0, 1'b1, n3);
    chk("spacing_4", n3 - n2, 4);
    drain();

    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge HCLK);
      w = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 6);
      issue($urandom, $urandom, 1'($urandom), w, 1'($urandom), $urandom,
            ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 3), (gap == 0), n1);
    end
    drain();

    issue(32'h1A10_4000, $urandom, 1'b0, NEVER, 1'b0, $urandom, 0, 1'b0, n1);
    n2 = 0;
    while (!(apb.psel && apb.penable) && n2 < 20) begin
      @(negedge HCLK);
      n2++;
    end
    chk("reached_access", {apb.psel, apb.penable}, 2'b11);
    in_reset = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_psel", apb.psel, 1'b0);
    chk("async_rst_penable", apb.penable, 1'b0);
    chk("async_rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("async_rst_req_ready", req_ready_o, 1'b1);
    chk("async_rst_rsp_rdata", rsp_rdata_o, 32'h0);
    sb.delete();
    sq.delete();
    @(negedge HCLK);
    HRESETn  = 1'b1;
    in_reset = 1'b0;
    repeat (6) begin
      @(negedge HCLK);
      chk("post_rst_no_rsp", rsp_valid_o, 1'b0);
      chk("post_rst_ready", req_ready_o, 1'b1);
    end
    issue(32'h1A10_5000, $urandom, 1'b0, 2, 1'b0, 32'h1234_5678, 0, 1'b0, n1);
    drain();
    repeat (2) @(negedge HCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
# apb_req_master

APB initiator that turns a simple valid/ready request channel from a core-side bridge or DMA into APB3 transfers. It drives the master end of an `APB_BUS` and returns one response per request. It applies a configurable watchdog so that a hung peripheral cannot stall the requester. It sits upstream of the APB interconnect and bus pass-through, and feeds the peripheral subsystem.

## Interface

Parameters:
- `APB_ADDR_WIDTH`, default 32: width of `paddr` and `req_addr_i`.
- `APB_DATA_WIDTH`, default 32: width of `pwdata`, `prdata`, `req_wdata_i` and `rsp_rdata_o`.
- `TIMEOUT_CYCLES`, default 256: maximum number of ACCESS cycles without `pready`. A value of 0 disables the timeout.

Ports:
- `HCLK`, in, 1: the single clock.
- `HRESETn`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, 1: a request is presented.
- `req_ready_o`, out, 1: the request is accepted on the cycle where valid and ready are both high.
- `req_addr_i`, in, `APB_ADDR_WIDTH`: transfer address.
- `req_wdata_i`, in, `APB_DATA_WIDTH`: write data.
- `req_we_i`, in, 1: 1 = write, 0 = read.
- `rsp_valid_o`, out, 1: a response is available.
- `rsp_ready_i`, in, 1: the requester consumes the response.
- `rsp_rdata_o`, out, `APB_DATA_WIDTH`: read data. It is 0 for writes and on timeout.
- `rsp_err_o`, out, 1: set on `pslverr` or on timeout.
- `apb_master`, `APB_BUS.Master` modport, carries `paddr`, `pwdata`, `pwrite`, `psel`, `penable`, `prdata`, `pready` and `pslverr`.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready_o` = 1.
  - On `req_valid_i`, register addr, wdata and we, then go to SETUP.
  - `req_ready_o` is 0 in every other state, so at most one transfer is outstanding.
- SETUP:
  - `psel` = 1, `penable` = 0, for exactly one cycle.
  - Go to ACCESS.
- ACCESS:
  - `psel` = 1, `penable` = 1.
  - If `pready` = 1:
    - Capture `prdata` (reads only; writes capture 0).
    - Set err to `pslverr`.
    - Go to RESP.
  - Otherwise increment the timeout counter.
  - When the counter reaches `TIMEOUT_CYCLES` (and the parameter is nonzero):
    - Set err = 1 and rdata = 0.
    - Go to RESP. `psel` and `penable` drop the next cycle.
  - If `pready` is high on the same cycle the counter reaches `TIMEOUT_CYCLES`, `pready` wins: normal completion, no timeout error.
- RESP:
  - `rsp_valid_o` = 1, with `rsp_rdata_o` and `rsp_err_o` held stable.
  - On `rsp_ready_i`, go to IDLE.
  - Response data never changes while `rsp_valid_o` is high.
- `paddr`, `pwdata` and `pwrite` come from registers. They are stable from SETUP through the last ACCESS cycle and hold their last value while idle.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide, clears on entry to SETUP, and saturates; it never wraps.
- `pslverr` and `prdata` are sampled only when `psel & penable & pready`.

## Timing

- All outputs are registers or decodes of the registered state; there are no combinational paths from inputs to outputs.
- Reset values: `req_ready_o` = 1 (IDLE), `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0, `psel` = 0, `penable` = 0, `pwrite` = 0, `paddr` = 0, `pwdata` = 0.
- Latency with zero wait states:
  - Request accepted at cycle N.
  - SETUP at N+1, ACCESS at N+2 (`pready` = 1).
  - `rsp_valid_o` at N+3.
  - With `rsp_ready_i` = 1, IDLE at N+4.
  - Throughput is therefore 1 transfer per 4 cycles.
- Each wait state adds 1 cycle.
- A timeout asserts `rsp_valid_o` at N+3+`TIMEOUT_CYCLES`.
- Reset asserted mid-transfer:
  - All outputs return to reset values asynchronously.
  - The transfer is abandoned and no response is issued.

## Structure

- Shared package `apb_req_master_pkg` holds:
  - the state enum `apb_mst_state_e` (IDLE, SETUP, ACCESS, RESP);
  - the request struct `apb_req_t` (addr, wdata, we) and response struct `apb_rsp_t` (rdata, err), parameterised through package localparams for 32-bit defaults.
- One sub-module, `apb_timeout_cnt`:
  - inputs: clear, enable;
  - output: an expired flag;
  - generate-disabled when `TIMEOUT_CYCLES` = 0.
- FSM and datapath registers live in the top module.

## Test plan

- Write 0x1A10_0004 ← 0xDEAD_BEEF with `pready` tied 1. Required:
  - SETUP at N+1 (`psel` = 1, `penable` = 0), ACCESS at N+2;
  - `paddr`, `pwdata` and `pwrite` = 1 stable across both cycles;
  - `rsp_valid_o` at N+3 with `rsp_err_o` = 0 and `rsp_rdata_o` = 0.
- Read from 0x1A10_1000, slave inserts 3 wait states then returns `prdata` = 0x0000_00A5. Required:
  - `rsp_rdata_o` = 0xA5 at N+6;
  - `paddr` stable for all 4 ACCESS cycles;
  - `req_ready_o` = 0 throughout.
- Read with `pslverr` = 1 and `pready` = 1. Required: `rsp_err_o` = 1, one transfer only.
- `TIMEOUT_CYCLES` = 4, `pready` held 0. Required:
  - `rsp_err_o` = 1 and `rsp_rdata_o` = 0 at N+7;
  - `psel` = 0 the following cycle.
  - Repeat with `pready` rising on the 4th ACCESS cycle: no error.
- Hold `rsp_ready_i` = 0 for 5 cycles, then issue back-to-back requests. Required:
  - the response stays stable while waiting;
  - the next request is accepted only in IDLE, with exactly 4-cycle spacing when `rsp_ready_i` = 1.
- Assert `HRESETn` = 0 during ACCESS. Required:
  - `psel`, `penable` and `rsp_valid_o` go to 0 immediately, without waiting for a clock edge;
  - after release, `req_ready_o` = 1 and no stale response is issued.
